sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_ctrl_if.sv | 34 +++
 rtl/sram_ctrl.sv | 150 +++++++++++++++
 tb/tb_sram_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TURN     = 3'd1,
        RD       = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
    } sram_ctrl_state_t;

    // Width of a down-counter that must hold the largest wait-state count.
    function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                              input int unsigned wr_wait,
                                              input int unsigned turn_cycles);
        int unsigned m;
        m = rd_wait;
        if (wr_wait > m)     m = wr_wait;
        if (turn_cycles > m) m = turn_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response port plus split SRAM pad signals of the SRAM controller.
interface sram_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  sram_ceb;
    logic                  sram_web;
    logic                  sram_oeb;
    logic [BE_WIDTH-1:0]   sram_beb;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_dout;
    logic                  sram_doe;
    logic [DATA_WIDTH-1:0] sram_din;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, sram_din,
        output req_ready, rd_valid, rd_data,
               sram_ceb, sram_web, sram_oeb, sram_beb, sram_addr, sram_dout, sram_doe
    );
endinterface

// File: rtl/sram_ctrl.sv
// Sequences single-outstanding requests into asynchronous SRAM read/write
// cycles with programmable wait states and read-to-write bus turnaround.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned RD_WAIT     = 2,
    parameter int unsigned WR_WAIT     = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input logic        clk,
    input logic        resetb,
    sram_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(RD_WAIT, WR_WAIT, TURN_CYCLES);

    sram_ctrl_state_t      state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  last_rd_q,   last_rd_d;
    logic [BE_WIDTH-1:0]   be_q,        be_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] dout_q,      dout_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
    logic                  rd_valid_q,  rd_valid_d;
    logic                  ready_q,     ready_d;
    logic                  ceb_q,       ceb_d;
    logic                  web_q,       web_d;
    logic                  oeb_q,       oeb_d;
    logic                  doe_q,       doe_d;
    logic [BE_WIDTH-1:0]   beb_q,       beb_d;

    // Next state, latched request fields, and strobes decoded from the next state
    // so every pad signal comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_rd_d  = last_rd_q;
        be_d       = be_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    be_d   = bus.req_be;
                    if (bus.req_we) begin
                        dout_d = bus.req_wdata;
                        if (last_rd_q && (TURN_CYCLES > 0)) begin
                            state_d = TURN;
                            cnt_d   = CNT_W'(TURN_CYCLES - 1);
                        end else begin
                            state_d = WR_SETUP;
                        end
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                    end
                end else begin
                    last_rd_d = 1'b0;
                end
            end
            TURN: begin
                if (cnt_q == '0) state_d = WR_SETUP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RD: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                    rd_data_d  = bus.sram_din;
                    last_rd_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CNT_W'(WR_WAIT - 1);
            end
            WR_PULSE: begin
                if (cnt_q == '0) state_d = WR_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WR_HOLD: begin
                state_d   = IDLE;
                last_rd_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        ceb_d   = !(state_d inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
        oeb_d   = (state_d != RD);
        web_d   = (state_d != WR_PULSE);
        doe_d   = (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
        beb_d   = ceb_d ? '1 : ~be_d;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_rd_q  <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            ceb_q      <= 1'b1;
            web_q      <= 1'b1;
            oeb_q      <= 1'b1;
            doe_q      <= 1'b0;
            beb_q      <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_rd_q  <= last_rd_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= ready_d;
            ceb_q      <= ceb_d;
            web_q      <= web_d;
            oeb_q      <= oeb_d;
            doe_q      <= doe_d;
            beb_q      <= beb_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.sram_ceb  = ceb_q;
    assign bus.sram_web  = web_q;
    assign bus.sram_oeb  = oeb_q;
    assign bus.sram_beb  = beb_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_dout = dout_q;
    assign bus.sram_doe  = doe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised bench for sram_ctrl: byte-lane SRAM device model plus a
// cycle-timeline reference derived from the request/latency rules.
module tb_sram_ctrl;

    localparam int RD_WAIT     = 2;
    localparam int WR_WAIT     = 2;
    localparam int TURN_CYCLES = 1;

    typedef struct packed {
        logic       ready;
        logic       ceb;
        logic       web;
        logic       oeb;
        logic       doe;
        logic [1:0] beb;
    } pat_t;

    logic clk;
    logic resetb;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    sram_ctrl_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) bus ();

    sram_ctrl #(
        .ADDR_WIDTH(18), .DATA_WIDTH(16), .BE_WIDTH(2),
        .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic pat_t mk(input logic rdy, input logic ceb, input logic web,
                                input logic oeb, input logic doe, input logic [1:0] beb);
        pat_t p;
        p.ready = rdy; p.ceb = ceb; p.web = web; p.oeb = oeb; p.doe = doe; p.beb = beb;
        return p;
    endfunction

    // Device: byte-lane async SRAM; unselected lanes read back as zero.
    logic [15:0] dev_mem [int];
    always @(negedge clk) begin
        if (!bus.sram_ceb && !bus.sram_web && bus.sram_doe)
            dev_mem[int'(bus.sram_addr)] = (dev_mem[int'(bus.sram_addr)] & ~lane_mask(~bus.sram_beb))
                                         | (bus.sram_dout & lane_mask(~bus.sram_beb));
        if (!bus.sram_ceb && !bus.sram_oeb)
            bus.sram_din = dev_mem[int'(bus.sram_addr)] & lane_mask(~bus.sram_beb);
        else
            bus.sram_din = 16'($urandom);
    end

    // Reference: word memory plus expected per-cycle pad activity.
    logic [15:0] ref_mem  [int];
    pat_t        exp_pat  [int];
    logic [17:0] exp_addr [int];
    logic [15:0] exp_dout [int];
    logic [15:0] rdv      [int];
    int          acc_q    [$];
    int          last_rd_end = -100;
    int          last_oeb_low = -100;
    int          last_gap = -1;
    logic        prev_doe = 1'b0;
    bit          mon_en = 1'b0;
    bit          relax_rd = 1'b0;
    logic [15:0] relax_got;

    pat_t idle_pat;
    pat_t e_p, o_p;
    int   cur, n0, t;
    assign idle_pat = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            cur = cyc;
            if (exp_pat.exists(cur)) begin e_p = exp_pat[cur]; exp_pat.delete(cur); end
            else e_p = idle_pat;
            o_p = mk(bus.req_ready, bus.sram_ceb, bus.sram_web, bus.sram_oeb, bus.sram_doe, bus.sram_beb);
            chk("strobes", 64'(o_p), 64'(e_p));
            if (exp_addr.exists(cur)) begin chk("addr", 64'(bus.sram_addr), 64'(exp_addr[cur])); exp_addr.delete(cur); end
            if (exp_dout.exists(cur)) begin chk("dout", 64'(bus.sram_dout), 64'(exp_dout[cur])); exp_dout.delete(cur); end
            chk("oe_doe_excl", 64'(!bus.sram_oeb && bus.sram_doe), 64'(0));
            if (rdv.exists(cur)) begin
                chk("rd_valid", 64'(bus.rd_valid), 64'(1));
                if (!relax_rd) chk("rd_data", 64'(bus.rd_data), 64'(rdv[cur]));
                relax_got = bus.rd_data;
                rdv.delete(cur);
            end else begin
                chk("rd_valid_idle", 64'(bus.rd_valid), 64'(0));
            end
            if (!bus.sram_oeb) last_oeb_low = cur;
            if (bus.sram_doe && !prev_doe) last_gap = cur - last_oeb_low - 1;
            prev_doe = bus.sram_doe;

            if (bus.req_valid && bus.req_ready) begin
                n0 = cur;
                acc_q.push_back(n0);
                if (!bus.req_we) begin
                    for (int k = 1; k <= RD_WAIT; k++) begin
                        exp_pat[n0+k]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ~bus.req_be);
                        exp_addr[n0+k] = bus.req_addr;
                    end
                    rdv[n0+RD_WAIT+1] = ref_mem[int'(bus.req_addr)] & lane_mask(bus.req_be);
                    last_rd_end = n0 + RD_WAIT + 1;
                end else begin
                    t = (n0 == last_rd_end && TURN_CYCLES > 0) ? TURN_CYCLES : 0;
                    for (int k = 1; k <= t; k++) exp_pat[n0+k] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
                    for (int k = t + 1; k <= t + 2 + WR_WAIT; k++) begin
                        exp_pat[n0+k]  = mk(1'b0, 1'b0, (k == t + 1 || k == t + 2 + WR_WAIT),
                                            1'b1, 1'b1, ~bus.req_be);
                        exp_addr[n0+k] = bus.req_addr;
                        exp_dout[n0+k] = bus.req_wdata;
                    end
                    ref_mem[int'(bus.req_addr)] = (ref_mem[int'(bus.req_addr)] & ~lane_mask(bus.req_be))
                                                | (bus.req_wdata & lane_mask(bus.req_be));
                end
            end
        end
    end

    // Called at negedge+1; leaves req_valid high one cycle after acceptance.
    task automatic send(input logic we, input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; bus.req_be = be; bus.req_valid = 1'b1;
        for (int i = 0; i < 64 && !bus.req_ready; i++) begin @(negedge clk); #1; end
        chk("accept", 64'(bus.req_ready), 64'(1));
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin @(negedge clk); #1; end
    endtask

    int          pool [11] = '{32'h5, 32'h10, 32'h11, 32'h20, 32'h21, 32'h22, 32'h23,
                               32'h3FFFF, 32'h15555, 32'h2AAAA, 32'h100};
    logic [15:0] old_v, new_v, v;
    int          base;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
        bus.sram_din = '0;
        foreach (pool[i]) begin v = 16'($urandom); ref_mem[pool[i]] = v; dev_mem[pool[i]] = v; end

        repeat (3) @(negedge clk);
        #2;
        chk("rst_ready",   64'(bus.req_ready), 64'(1));
        chk("rst_rdvalid", 64'(bus.rd_valid),  64'(0));
        chk("rst_rddata",  64'(bus.rd_data),   64'(0));
        chk("rst_strobes", 64'({bus.sram_ceb, bus.sram_web, bus.sram_oeb, bus.sram_doe, bus.sram_beb}), 64'(6'b111011));
        chk("rst_addr",    64'(bus.sram_addr), 64'(0));
        chk("rst_dout",    64'(bus.sram_dout), 64'(0));
        @(negedge clk); #1;
        resetb = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Full-word write then read back.
        send(1'b1, 18'h00005, 16'h1234, 2'b11);
        send(1'b0, 18'h00005, 16'h0000, 2'b11);
        idle(RD_WAIT + 2);
        chk("t1_data", 64'(bus.rd_data), 64'(16'h1234));

        // Low-lane write merges into existing word.
        send(1'b1, 18'h00005, 16'hABCD, 2'b01);
        send(1'b0, 18'h00005, 16'h0000, 2'b11);
        idle(RD_WAIT + 2);
        chk("t2_data", 64'(bus.rd_data), 64'(16'h12CD));

        // Read immediately followed by write: accept cycle plus turnaround idle.
        idle(2);
        send(1'b0, 18'h00010, 16'h0000, 2'b11);
        send(1'b1, 18'h00011, 16'h5555, 2'b11);
        idle(WR_WAIT + TURN_CYCLES + 4);
        chk("turn_gap", 64'(last_gap), 64'(1 + TURN_CYCLES));

        // Four back-to-back reads with valid held.
        base = acc_q.size();
        for (int i = 0; i < 4; i++) send(1'b0, 18'(32'h20 + i), 16'h0000, 2'b11);
        idle(RD_WAIT + 2);
        for (int i = 0; i < 3; i++) chk("b2b_period", 64'(acc_q[base+i+1] - acc_q[base+i]), 64'(RD_WAIT + 1));

        // Top address, no wrap.
        send(1'b1, 18'h3FFFF, 16'hFFFF, 2'b11);
        send(1'b0, 18'h3FFFF, 16'h0000, 2'b11);
        idle(RD_WAIT + 2);
        chk("top_data", 64'(bus.rd_data), 64'(16'hFFFF));

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            send(1'($urandom), 18'(pool[$urandom_range(0, 10)]), 16'($urandom), 2'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(WR_WAIT + TURN_CYCLES + 4);

        // Reset during the write pulse.
        old_v = ref_mem[32'h3FFFF];
        new_v = ~old_v;
        send(1'b1, 18'h3FFFF, new_v, 2'b11);
        @(negedge clk); #1;
        bus.req_valid = 1'b0;
        mon_en = 1'b0;
        chk("pulse_web", 64'(bus.sram_web), 64'(0));
        resetb = 1'b0;
        #1;
        chk("abort_strobes", 64'({bus.sram_ceb, bus.sram_web, bus.sram_oeb, bus.sram_doe}), 64'(4'b1110));
        chk("abort_rdvalid", 64'(bus.rd_valid), 64'(0));
        repeat (2) @(negedge clk);
        exp_pat.delete(); exp_addr.delete(); exp_dout.delete(); rdv.delete();
        last_rd_end = -100; prev_doe = 1'b0;
        #1 resetb = 1'b1;
        @(negedge clk); #1;
        mon_en = 1'b1;
        relax_rd = 1'b1;
        send(1'b0, 18'h3FFFF, 16'h0000, 2'b11);
        idle(RD_WAIT + 2);
        relax_rd = 1'b0;
        chk("abort_loc", 64'(!$isunknown(relax_got) && (relax_got == old_v || relax_got == new_v)), 64'(1));
        ref_mem[32'h3FFFF] = relax_got;

        send(1'b0, 18'h3FFFF, 16'h0000, 2'b11);
        idle(RD_WAIT + 4);
        chk("pending_rd", 64'(rdv.num()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
